// File: rtl/mem_bus_arbiter.sv
// Two-master (IF, LS) arbiter for one single-port memory.
// Ports: if_* fetch, ls_* load/store, mem_* memory side, err_o timeout.
module mem_bus_arbiter #(
  parameter int unsigned MAX_LS_STREAK = 3,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_LS
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tmo_q, tmo_d;

  logic in_wait, rsp, tmo_exp, arb_en;
  logic force_if, win_if, win_ls, gnt;

  assign in_wait  = (state_q != IDLE);
  assign rsp      = in_wait & mem_rvalid_i;
  // tmo_q counts WAIT cycles already spent, so expiry
  // lands in the TIMEOUT-th WAIT cycle; a response wins.
  assign tmo_exp  = in_wait & ~mem_rvalid_i &
                    (tmo_q == 8'(TIMEOUT - 1));
  // rst_n gates the IDLE path so nothing leaks out
  // combinationally while reset is held.
  assign arb_en   = rst_n & ((state_q == IDLE) | rsp);
  assign force_if = (streak_q == 4'(MAX_LS_STREAK));
  assign win_if   = arb_en & if_req_i &
                    (~ls_req_i | force_if);
  assign win_ls   = arb_en & ls_req_i & ~win_if;
  assign gnt      = mem_gnt_i & (win_if | win_ls);

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    unique case (1'b1)
      win_if: begin
        mem_req_o  = 1'b1;
        mem_be_o   = 4'hF;
        mem_addr_o = if_addr_i;
      end
      win_ls: begin
        mem_req_o   = 1'b1;
        mem_we_o    = ls_we_i;
        mem_be_o    = ls_be_i;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_wdata_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    if_gnt_o    = mem_gnt_i & win_if;
    ls_gnt_o    = mem_gnt_i & win_ls;
    if_rvalid_o = (rsp | tmo_exp) & (state_q == WAIT_IF);
    ls_rvalid_o = (rsp | tmo_exp) & (state_q == WAIT_LS);
    if_rdata_o  = 32'h0;
    ls_rdata_o  = 32'h0;
    if (rsp && state_q == WAIT_IF) if_rdata_o = mem_rdata_i;
    if (rsp && state_q == WAIT_LS) ls_rdata_o = mem_rdata_i;
    err_o       = tmo_exp;
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    tmo_d    = tmo_q;
    if (gnt) begin
      state_d = win_if ? WAIT_IF : WAIT_LS;
      tmo_d   = 8'h0;
      if (win_if || !if_req_i) begin
        streak_d = 4'h0;
      end else if (!force_if) begin
        streak_d = streak_q + 4'h1;
      end
    end else if (rsp || tmo_exp) begin
      state_d = IDLE;
    end else if (in_wait) begin
      tmo_d = tmo_q + 8'h1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      streak_q <= 4'h0;
      tmo_q    <= 8'h0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter.
// Directed steps; expected responses queued at grant.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .MAX_LS_STREAK(3),
    .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i),
    .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  typedef struct {
    bit          ls;
    logic [31:0] data;
    bit          err;
  } rsp_t;

  rsp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input bit ls, input logic [31:0] d,
                      input bit e);
    rsp_t r;
    r.ls   = ls;
    r.data = d;
    r.err  = e;
    sb.push_back(r);
  endtask

  task automatic chk_rsp(input string tag);
    rsp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty queue expected entry",
             tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".if_rvalid"}, 32'(if_rvalid_o), 32'(!e.ls));
    chk({tag, ".ls_rvalid"}, 32'(ls_rvalid_o), 32'(e.ls));
    chk({tag, ".if_rdata"}, if_rdata_o,
        e.ls ? 32'h0 : e.data);
    chk({tag, ".ls_rdata"}, ls_rdata_o,
        e.ls ? e.data : 32'h0);
    chk({tag, ".err"}, 32'(err_o), 32'(e.err));
  endtask

  task automatic no_rsp(input string tag);
    chk({tag, ".if_rvalid"}, 32'(if_rvalid_o), 32'h0);
    chk({tag, ".ls_rvalid"}, 32'(ls_rvalid_o), 32'h0);
    chk({tag, ".if_rdata"}, if_rdata_o, 32'h0);
    chk({tag, ".ls_rdata"}, ls_rdata_o, 32'h0);
    chk({tag, ".err"}, 32'(err_o), 32'h0);
  endtask

  task automatic idle_in();
    if_req_i     = 1'b0;
    if_addr_i    = 32'h0;
    ls_req_i     = 1'b0;
    ls_we_i      = 1'b0;
    ls_be_i      = 4'h0;
    ls_addr_i    = 32'h0;
    ls_wdata_i   = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ord[8];
    ord = '{0, 0, 0, 1, 0, 0, 0, 1};

    idle_in();
    rst_n = 1'b0;
    if_req_i  = 1'b1;
    ls_req_i  = 1'b1;
    ls_be_i   = 4'hF;
    ls_addr_i = 32'h1234;
    mem_gnt_i = 1'b1;
    settle();
    chk("rst.mem_req", 32'(mem_req_o), 32'h0);
    chk("rst.if_gnt", 32'(if_gnt_o), 32'h0);
    chk("rst.ls_gnt", 32'(ls_gnt_o), 32'h0);
    chk("rst.mem_be", 32'(mem_be_o), 32'h0);
    chk("rst.mem_addr", mem_addr_o, 32'h0);
    no_rsp("rst");
    adv();
    adv();
    idle_in();
    rst_n = 1'b1;
    adv();

    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    mem_gnt_i = 1'b1;
    settle();
    chk("if1.gnt", 32'(if_gnt_o), 32'h1);
    chk("if1.ls_gnt", 32'(ls_gnt_o), 32'h0);
    chk("if1.addr", mem_addr_o, 32'h100);
    chk("if1.be", 32'(mem_be_o), 32'hF);
    chk("if1.we", 32'(mem_we_o), 32'h0);
    push(1'b0, 32'h13, 1'b0);
    adv();
    idle_in();
    settle();
    chk("if1.c1.mem_req", 32'(mem_req_o), 32'h0);
    no_rsp("if1.c1");
    adv();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h13;
    settle();
    chk_rsp("if1.c2");
    adv();
    idle_in();
    ls_req_i = 1'b1;
    settle();
    chk("if1.idle.mem_req", 32'(mem_req_o), 32'h1);
    chk("if1.idle.ls_gnt", 32'(ls_gnt_o), 32'h0);
    adv();

    idle_in();
    ls_req_i   = 1'b1;
    ls_we_i    = 1'b1;
    ls_be_i    = 4'b0011;
    ls_addr_i  = 32'h2000;
    ls_wdata_i = 32'hDEADBEEF;
    mem_gnt_i  = 1'b1;
    settle();
    chk("wr.gnt", 32'(ls_gnt_o), 32'h1);
    chk("wr.we", 32'(mem_we_o), 32'h1);
    chk("wr.be", 32'(mem_be_o), 32'h3);
    chk("wr.addr", mem_addr_o, 32'h2000);
    chk("wr.wdata", mem_wdata_o, 32'hDEADBEEF);
    push(1'b1, 32'h0, 1'b0);
    adv();
    idle_in();
    mem_rvalid_i = 1'b1;
    settle();
    chk_rsp("wr.ack");
    adv();

    for (int i = 0; i < 8; i++) begin
      idle_in();
      if_req_i     = 1'b1;
      if_addr_i    = 32'h300;
      ls_req_i     = 1'b1;
      ls_be_i      = 4'hF;
      ls_addr_i    = 32'h400;
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = (i > 0);
      mem_rdata_i  = 32'hA0 + 32'(i);
      settle();
      if (i > 0) chk_rsp($sformatf("str%0d.rsp", i));
      chk($sformatf("str%0d.if_gnt", i),
          32'(if_gnt_o), 32'(ord[i]));
      chk($sformatf("str%0d.ls_gnt", i),
          32'(ls_gnt_o), 32'(!ord[i]));
      chk($sformatf("str%0d.addr", i), mem_addr_o,
          ord[i] ? 32'h300 : 32'h400);
      push(!ord[i], 32'hA0 + 32'(i + 1), 1'b0);
      adv();
    end
    idle_in();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hA8;
    settle();
    chk_rsp("str.last");
    adv();

    idle_in();
    ls_req_i  = 1'b1;
    ls_be_i   = 4'hF;
    ls_addr_i = 32'h40;
    mem_gnt_i = 1'b1;
    settle();
    chk("to.gnt", 32'(ls_gnt_o), 32'h1);
    push(1'b1, 32'h0, 1'b1);
    adv();
    idle_in();
    for (int c = 1; c < 16; c++) begin
      settle();
      no_rsp($sformatf("to.w%0d", c));
      adv();
    end
    settle();
    chk_rsp("to.w16");
    adv();
    adv();
    adv();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h55;
    settle();
    no_rsp("to.late");
    adv();

    idle_in();
    ls_req_i  = 1'b1;
    ls_be_i   = 4'hF;
    ls_addr_i = 32'h44;
    mem_gnt_i = 1'b1;
    settle();
    push(1'b1, 32'h77, 1'b0);
    adv();
    idle_in();
    for (int c = 1; c < 16; c++) adv();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h77;
    settle();
    chk_rsp("race.w16");
    adv();

    idle_in();
    if_req_i  = 1'b1;
    if_addr_i = 32'h500;
    mem_gnt_i = 1'b1;
    settle();
    chk("rw.gnt", 32'(if_gnt_o), 32'h1);
    adv();
    idle_in();
    rst_n        = 1'b0;
    ls_req_i     = 1'b1;
    ls_be_i      = 4'hF;
    ls_addr_i    = 32'h600;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h99;
    settle();
    chk("rw.mem_req", 32'(mem_req_o), 32'h0);
    chk("rw.ls_gnt", 32'(ls_gnt_o), 32'h0);
    chk("rw.mem_addr", mem_addr_o, 32'h0);
    no_rsp("rw.inrst");
    adv();
    idle_in();
    rst_n        = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h99;
    settle();
    no_rsp("rw.post");
    adv();
    idle_in();
    if_req_i  = 1'b1;
    if_addr_i = 32'h700;
    settle();
    chk("rw.idle.mem_req", 32'(mem_req_o), 32'h1);
    chk("rw.idle.addr", mem_addr_o, 32'h700);
    chk("rw.idle.gnt", 32'(if_gnt_o), 32'h0);
    mem_gnt_i = 1'b1;
    settle();
    chk("rw.gnt2", 32'(if_gnt_o), 32'h1);
    push(1'b0, 32'h31, 1'b0);
    adv();
    idle_in();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h31;
    settle();
    chk_rsp("rw.rsp");
    adv();

    idle_in();
    chk("sb.empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port instruction/data memory between two requesters: instruction fetch (IF, master 0) and load/store (LS, master 1, from the MEM stage).
- Sequences one outstanding memory transaction at a time using a req/gnt/rvalid handshake.
- Applies LS-priority arbitration with a starvation guard for IF, and a response timeout.
- Sits between the IF/MEM stages of the 5-stage RV32I pipeline and the memory; its gnt/rvalid outputs drive pipeline hold decisions.

Parameters:
- MAX_LS_STREAK, 3, consecutive LS grants allowed while IF is pending before IF is forced to win; legal range 1..15.
- TIMEOUT, 16, cycles in a WAIT state without mem_rvalid_i before an error response; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req_i  in  1  IF read request; held until if_gnt_o.
- if_addr_i  in  32  IF word address.
- if_gnt_o  out  1  IF request accepted this cycle.
- if_rvalid_o  out  1  IF read data valid, one-cycle pulse.
- if_rdata_o  out  32  IF read data; 0 when if_rvalid_o is 0.
- ls_req_i  in  1  LS request; held until ls_gnt_o.
- ls_we_i  in  1  LS write enable.
- ls_be_i  in  4  LS byte enables.
- ls_addr_i  in  32  LS address.
- ls_wdata_i  in  32  LS write data.
- ls_gnt_o  out  1  LS request accepted this cycle.
- ls_rvalid_o  out  1  LS response valid (reads and write acks), one-cycle pulse.
- ls_rdata_o  out  32  LS read data; 0 when ls_rvalid_o is 0.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  memory response valid (returned for writes too).
- mem_rdata_i  in  32  memory read data.
- err_o  out  1  one-cycle pulse when a response times out.

Behaviour:
- Reset: clk, asynchronous active-low reset rst_n. While rst_n=0:
  - State returns to IDLE.
  - All gnt/rvalid/err outputs, mem_req_o, mem_we_o and mem_be_o are 0; rdata and mem_addr/wdata are 0.
  - Streak and timeout counters are cleared.
  - Any in-flight transaction is abandoned.
- States: IDLE, WAIT_IF, WAIT_LS.
- Arbitration is combinational and is active in IDLE, and in WAIT_x during the cycle mem_rvalid_i=1.
  - Only one requester: that requester wins.
  - Both requesting: LS wins unless ls_streak==MAX_LS_STREAK, in which case IF wins.
- Request phase:
  - While arbitrating with a winner, mem_req_o=1 and the mem_* fields mux combinationally from the winner.
  - For IF: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
  - x_gnt_o = mem_gnt_i & (winner==x), same cycle.
  - On a grant, the next state is WAIT_IF or WAIT_LS per the winner. Without a grant, the state is unchanged and the requester must keep req and fields stable.
- WAIT states:
  - No new request is issued except in the cycle mem_rvalid_i=1.
  - That cycle: owner x_rvalid_o=1 and x_rdata_o=mem_rdata_i, both combinational, zero latency.
  - A new arbitration happens in the same cycle (back-to-back). If it is granted, move to the new WAIT state; otherwise go to IDLE.
- Minimum latency: req to gnt is 0 cycles; gnt to rvalid is ≥1 cycle, set by the memory. Peak throughput is 1 transaction per cycle.
- Streak counter (4-bit):
  - On an LS grant with if_req_i=1: increment, saturating at MAX_LS_STREAK.
  - On an LS grant with if_req_i=0: clear.
  - On an IF grant: clear.
- Timeout counter:
  - Clears on entry to a WAIT state and increments each WAIT cycle without mem_rvalid_i.
  - When it reaches TIMEOUT: owner x_rvalid_o=1 with rdata=0, err_o=1 for one cycle, state goes to IDLE, no arbitration that cycle.
  - A mem_rvalid_i arriving later, in IDLE, is ignored.
- Stray mem_rvalid_i in IDLE: ignored; no rvalid to either requester.
- mem_rvalid_i and timeout expiry in the same cycle: the valid response wins, err_o=0.
- Requester dropping req before its grant: legal; arbitration re-evaluates next cycle.
- Reset mid-WAIT: no response is delivered after reset release.

Test Plan:
- Single IF read, addr 0x100, mem_gnt_i in the same cycle, mem_rvalid_i 2 cycles later with 0x00000013 -> if_gnt_o=1 in cycle 0; if_rvalid_o=1 and if_rdata_o=0x13 in cycle 2; state returns to IDLE.
- IF and LS both requesting continuously, memory with a 1-cycle response, MAX_LS_STREAK=3 -> grant order LS,LS,LS,IF,LS,LS,LS,IF; the streak counter never exceeds 3.
- LS write addr 0x2000, be=4'b0011, wdata 0xDEADBEEF -> mem_we_o=1, mem_be_o=0011 and the address/data pass through in the grant cycle; ls_rvalid_o on the ack; IF gets no rvalid.
- Back-to-back: mem_rvalid_i for IF in the same cycle as a pending LS request with mem_gnt_i=1 -> if_rvalid_o=1 and ls_gnt_o=1 in that cycle; next state WAIT_LS.
- Timeout: LS granted, no mem_rvalid_i for 16 cycles (TIMEOUT=16) -> in the 16th WAIT cycle ls_rvalid_o=1, ls_rdata_o=0, err_o=1; a late mem_rvalid_i 3 cycles later produces no rvalid.
- Reset asserted in WAIT_IF, released, then mem_rvalid_i=1 -> if_rvalid_o stays 0, all outputs stay 0 during reset, the next request arbitrates from IDLE.
